// File: rtl/aes_uart_dump.sv
// aes_uart_dump
// -------------
// Sends the AES-128 ciphertext out of a UART TX pin as uppercase ASCII hex,
// most-significant nibble first. A dump starts on a rising edge of the AES
// core's done level and sends 32 characters, each framed 8N1.
//
// Optional build macro: UART_DUMP_CRLF_EN
//   When defined, CR (0x0D) and LF (0x0A) follow the 32 hex characters, so
//   each dump is 34 characters long.
//
// Parameters:
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       UART bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD
//
// Ports:
//   clk        system clock, rising edge
//   rst        asynchronous, active-high reset
//   done       AES core done level; a 0->1 transition starts a dump
//   ciphertext AES core output, sampled only on the capture cycle
//   tx         UART serial output, idle high
//   busy       high from the capture cycle until the last stop bit ends
//   dump_done  one-cycle pulse after the final character's stop bit
//   dbg_state  current FSM state, for debug and checkers
//
// Handshake: there is no ready/valid here. done is an edge-triggered request;
// a rising edge seen while busy is high is dropped, never queued.

module aes_uart_dump #(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 115200
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         done,
    input  logic [127:0] ciphertext,
    output logic         tx,
    output logic         busy,
    output logic         dump_done,
    output logic [2:0]   dbg_state
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

`ifdef UART_DUMP_CRLF_EN
    localparam int NUM_CHARS = 34;
`else
    localparam int NUM_CHARS = 32;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        NEXT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [5:0]       char_cnt_q, char_cnt_d;   // characters loaded so far
    logic [127:0]     shreg_q, shreg_d;
    logic [7:0]       char_q, char_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             dump_done_q, dump_done_d;
    logic             done_q, done_d;
    logic             trigger;

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        if (n < 4'd10) begin
            return 8'h30 + {4'h0, n};
        end
        return 8'h37 + {4'h0, n};
    endfunction

    // Character for slot cnt; the shift register already holds the next
    // nibble in its top four bits.
    function automatic logic [7:0] next_char(input logic [5:0] cnt,
                                             input logic [3:0] nib);
`ifdef UART_DUMP_CRLF_EN
        if (cnt == 6'd32) begin
            return 8'h0D;
        end
        if (cnt == 6'd33) begin
            return 8'h0A;
        end
`else
        if (cnt > 6'd63) begin
            return 8'h00;   // unreachable, keeps cnt used in this build
        end
`endif
        return hex_ascii(nib);
    endfunction

    assign trigger = done & ~done_q;

    always_comb begin
        state_d     = state_q;
        baud_cnt_d  = baud_cnt_q;
        bit_idx_d   = bit_idx_q;
        char_cnt_d  = char_cnt_q;
        shreg_d     = shreg_q;
        char_d      = char_q;
        tx_d        = tx_q;
        busy_d      = busy_q;
        dump_done_d = 1'b0;
        done_d      = done;

        case (state_q)
            IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (trigger) begin
                    char_d     = hex_ascii(ciphertext[127:124]);
                    shreg_d    = {ciphertext[123:0], 4'h0};
                    char_cnt_d = 6'd1;
                    baud_cnt_d = '0;
                    tx_d       = 1'b0;
                    busy_d     = 1'b1;
                    state_d    = START;
                end
            end
            START: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    bit_idx_d  = 3'd0;
                    tx_d       = char_q[0];
                    state_d    = DATA;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = 3'd0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = char_q[bit_idx_q + 3'd1];
                    end
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (baud_cnt_q == BAUD_LAST) begin
                    baud_cnt_d = '0;
                    state_d    = NEXT;
                end else begin
                    baud_cnt_d = baud_cnt_q + 1'b1;
                end
            end
            NEXT: begin
                if (char_cnt_q < 6'(NUM_CHARS)) begin
                    char_d     = next_char(char_cnt_q, shreg_q[127:124]);
                    shreg_d    = {shreg_q[123:0], 4'h0};
                    char_cnt_d = char_cnt_q + 6'd1;
                    tx_d       = 1'b0;
                    state_d    = START;
                end else begin
                    dump_done_d = 1'b1;
                    busy_d      = 1'b0;
                    char_cnt_d  = 6'd0;
                    tx_d        = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    // Async reset forces tx high the moment rst rises, abandoning any frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            baud_cnt_q  <= '0;
            bit_idx_q   <= 3'd0;
            char_cnt_q  <= 6'd0;
            shreg_q     <= '0;
            char_q      <= 8'h00;
            tx_q        <= 1'b1;
            busy_q      <= 1'b0;
            dump_done_q <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            baud_cnt_q  <= baud_cnt_d;
            bit_idx_q   <= bit_idx_d;
            char_cnt_q  <= char_cnt_d;
            shreg_q     <= shreg_d;
            char_q      <= char_d;
            tx_q        <= tx_d;
            busy_q      <= busy_d;
            dump_done_q <= dump_done_d;
            done_q      <= done_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign dump_done = dump_done_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_aes_uart_dump.sv
// Testbench for aes_uart_dump. Runs with a small CLKS_PER_BIT so full dumps
// fit in a short simulation; a UART receiver decodes tx and compares each
// character against an expected queue built from the ciphertext nibbles.
module tb_aes_uart_dump;

  localparam int CLK_FREQ = 40;
  localparam int BAUD     = 10;
  localparam int CPB      = CLK_FREQ / BAUD;
  localparam int FRAME    = 10 * CPB + 1;
`ifdef UART_DUMP_CRLF_EN
  localparam int NCH = 34;
`else
  localparam int NCH = 32;
`endif
  localparam logic [127:0] KNOWN = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         done;
  logic [127:0] ciphertext;
  logic         tx;
  logic         busy;
  logic         dump_done;
  logic [2:0]   dbg_state;

  always #5 clk = ~clk;

  aes_uart_dump #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk        (clk),
    .rst        (rst),
    .done       (done),
    .ciphertext (ciphertext),
    .tx         (tx),
    .busy       (busy),
    .dump_done  (dump_done),
    .dbg_state  (dbg_state)
  );

  int errors = 0;
  int checks = 0;

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];
  logic [7:0] last_bits;

  // Expected ASCII stream: each nibble of the ciphertext as a hex digit,
  // most significant first, optionally followed by CR LF.
  function automatic void build_exp(input logic [127:0] ct);
    logic [3:0] n;
    for (int i = 0; i < 32; i++) begin
      n = ct[127 - 4*i -: 4];
      if (n < 4'd10) exp_q.push_back(8'h30 + 8'(n));
      else           exp_q.push_back(8'h41 + 8'(n) - 8'd10);
    end
`ifdef UART_DUMP_CRLF_EN
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
`endif
  endfunction

  // ---------------- output monitor ----------------
  int   busy_cnt      = 0;
  int   last_busy_len = 0;
  int   dd_cycles     = 0;
  int   dd_bad        = 0;
  logic prev_busy     = 1'b0;

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cnt++;
    else if (prev_busy === 1'b1) begin
      last_busy_len = busy_cnt;
      busy_cnt      = 0;
    end
    if (dump_done === 1'b1) begin
      dd_cycles++;
      if (busy !== 1'b0 || prev_busy !== 1'b1) dd_bad++;
    end
    prev_busy = busy;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- driver / receiver tasks ----------------
  // Called at a negedge in IDLE; returns at the negedge just after the
  // trigger edge, with done dropped again.
  task automatic trigger(input logic [127:0] ct, input string name);
    @(negedge clk);
    ciphertext = ct;
    done       = 1'b1;
    checks++;
    if (tx !== 1'b1) begin
      errors++;
      $display("FAIL %s_pre_tx: tx=%b required 1", name, tx);
    end
    @(negedge clk);
    done = 1'b0;
    checks++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s_latency: tx=%b busy=%b required tx=0 busy=1", name, tx, busy);
    end
  endtask

  // Samples each bit in its middle, starting half a cycle into the start bit.
  task automatic recv_char(output logic [7:0] c, output bit ok);
    int w;
    w  = 0;
    ok = 1'b0;
    c  = 8'h00;
    while (tx !== 1'b0 && w < 3 * FRAME) begin
      @(negedge clk);
      w++;
    end
    if (tx !== 1'b0) return;
    repeat (CPB / 2) @(negedge clk);
    if (tx !== 1'b0) return;
    for (int i = 0; i < 8; i++) begin
      repeat (CPB) @(negedge clk);
      c[i] = tx;
    end
    repeat (CPB) @(negedge clk);
    if (tx !== 1'b1) return;
    ok = 1'b1;
  endtask

  task automatic recv_dump(input string name);
    logic [7:0] c;
    logic [7:0] e;
    bit         ok;
    int         k;
    k = 0;
    while (exp_q.size() > 0) begin
      recv_char(c, ok);
      checks++;
      if (!ok) begin
        errors++;
        $display("FAIL %s_frame: char %0d not received (got %02h) required %02h",
                 name, k, c, exp_q[0]);
        exp_q.delete();
        return;
      end
      if (k == 0) last_bits = c;
      e = exp_q.pop_front();
      if (c !== e) begin
        errors++;
        $display("FAIL %s_char%0d: got %02h required %02h", name, k, c, e);
      end
      k++;
    end
  endtask

  task automatic wait_idle(input string name);
    int w;
    w = 0;
    while (busy !== 1'b0 && w < 2 * FRAME) begin
      @(negedge clk);
      w++;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle: busy=%b required 0", name, busy);
    end
  endtask

  task automatic quiet_check(input string name, input int cycles);
    int active;
    active = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) active++;
    end
    checks++;
    if (active != 0) begin
      errors++;
      $display("FAIL %s_quiet: %0d active cycles required 0", name, active);
    end
  endtask

  task automatic check_dump_stats(input string name, input int dd0);
    checks++;
    if (last_busy_len != NCH * FRAME) begin
      errors++;
      $display("FAIL %s_busy_len: %0d required %0d", name, last_busy_len, NCH * FRAME);
    end
    checks++;
    if (dd_cycles - dd0 != 1 || dd_bad != 0) begin
      errors++;
      $display("FAIL %s_dump_done: pulses=%0d bad=%0d required 1 and 0",
               name, dd_cycles - dd0, dd_bad);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst        = 1'b1;
    done       = 1'b0;
    ciphertext = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: %b required 1", tx); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: %b required 0", busy); end
    checks++;
    if (dump_done !== 1'b0) begin
      errors++; $display("FAIL reset_dump_done: %b required 0", dump_done);
    end
    checks++;
    if (dbg_state !== 3'd0) begin
      errors++; $display("FAIL reset_state: %0d required 0", dbg_state);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_known_vector();
    int dd0;
    dd0 = dd_cycles;
    build_exp(KNOWN);
    trigger(KNOWN, "known");
    recv_dump("known");
    wait_idle("known");
    check_dump_stats("known", dd0);
  endtask

  task automatic test_nibbles();
    logic [127:0] ct;
    bit exp_bits[8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    ct = {16'h09af, 112'h0};
    build_exp(ct);
    trigger(ct, "nib");
    recv_dump("nib");
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (last_bits[i] !== exp_bits[i]) begin
        errors++;
        $display("FAIL nib_bit%0d: %b required %b", i, last_bits[i], exp_bits[i]);
      end
    end
    wait_idle("nib");
  endtask

  task automatic test_random();
    logic [127:0] ct;
    int dd0;
    for (int r = 0; r < 3; r++) begin
      ct  = {$urandom, $urandom, $urandom, $urandom};
      dd0 = dd_cycles;
      build_exp(ct);
      trigger(ct, "rand");
      recv_dump("rand");
      wait_idle("rand");
      check_dump_stats("rand", dd0);
    end
  endtask

  task automatic test_busy_ignore();
    logic [127:0] a;
    int dd0;
    a   = {$urandom, $urandom, $urandom, $urandom};
    dd0 = dd_cycles;
    build_exp(a);
    trigger(a, "ign");
    fork
      recv_dump("ign");
      begin
        repeat ($urandom_range(20, 25 * FRAME)) @(negedge clk);
        ciphertext = ~a;
        done       = 1'b1;
        @(negedge clk);
        done = 1'b0;
      end
    join
    wait_idle("ign");
    check_dump_stats("ign", dd0);
    quiet_check("ign", 3 * FRAME);
  endtask

  task automatic reset_mid_dump(input string name);
    logic [127:0] ct;
    ct = {$urandom, $urandom, $urandom, $urandom};
    trigger(ct, name);
    repeat (CPB + 2 + $urandom_range(0, 6 * CPB)) @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (tx !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_async: tx=%b busy=%b required tx=1 busy=0", name, tx, busy);
    end
  endtask

  task automatic test_reset_mid();
    logic [127:0] b;
    logic [127:0] c;
    // done held high through reset release: exactly one dump
    reset_mid_dump("rsta");
    done = 1'b1;
    b    = {$urandom, $urandom, $urandom, $urandom};
    ciphertext = b;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    build_exp(b);
    recv_dump("rsta");
    wait_idle("rsta");
    // done still held high: no second dump
    quiet_check("held", 3 * FRAME);
    // fresh edge dumps the ciphertext present at that moment
    done = 1'b0;
    repeat (2) @(negedge clk);
    c = {$urandom, $urandom, $urandom, $urandom};
    build_exp(c);
    trigger(c, "refire");
    recv_dump("refire");
    wait_idle("refire");
    // done low through reset release: nothing starts
    reset_mid_dump("rstb");
    done = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    quiet_check("rstb", 3 * FRAME);
  endtask

  initial begin
    test_reset();
    test_known_vector();
    test_nibbles();
    test_random();
    test_busy_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
